grant_decoder3to8: RTL and testbench
====================================

Name: grant_decoder3to8

Overview:
- Registered 3-to-8 grant decoder: the consumer side of the 8-to-3 priority encoder's index/valid output.
- Accepts one encoded index through a valid/ready handshake and drives the matching one-hot grant line.
- Holds the grant until the granted client pulses release, or until an optional hold timeout expires.
- Sits between the priority encoder and the eight requesting clients.

Parameters:
- IDX_W, 3, index width; N = 2**IDX_W grant lines (localparam, 8 by default).
- HOLD_MAX, 15, maximum grant cycles before forced release (timeout build only); legal range >= 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_idx  input  IDX_W  encoded index from the priority encoder.
- in_valid  input  1  in_idx is valid.
- in_ready  output  1  decoder can accept an index this cycle.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  a grant is currently held.
- grant_idx  output  IDX_W  registered copy of the accepted index.
- release_i  input  1  granted client frees the grant.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, grant=0, grant_valid=0, grant_idx=0, timeout=0, hold counter=0.
- States: IDLE, GRANT.
- in_ready = (state==IDLE) && !rst. It is combinational from state only, with no path from in_valid.
- IDLE: in_valid && in_ready accepts the index.
  - Next cycle: state=GRANT, grant = 1<<in_idx, grant_valid=1, grant_idx=in_idx, counter=0.
  - Latency: grant appears 1 cycle after acceptance.
- GRANT: in_ready=0. in_valid is ignored, and the producer holds in_idx/in_valid stable.
- GRANT with release_i=1: next cycle state=IDLE, grant=0, grant_valid=0. in_ready rises that same cycle.
  - Minimum grant duration is 1 cycle; an index can be accepted on the cycle after release.
- release_i in IDLE: ignored, no effect.
- grant stays exactly one-hot, or all-zero, at all times; it never changes while in GRANT.
- grant_idx holds its last value in IDLE, and is meaningful only while grant_valid=1.
- Reset mid-grant: grant and grant_valid clear on the next edge with rst=1. in_ready=1 on the first cycle after rst deasserts.
- Width rule: N = 2**IDX_W, so every in_idx value is legal. No out-of-range handling is needed.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - Hold counter, width $clog2(HOLD_MAX+1), increments each GRANT cycle without release_i.
  - On the HOLD_MAX-th grant cycle (counter==HOLD_MAX-1) with release_i=0: next cycle state=IDLE, grant=0, grant_valid=0, timeout=1 for exactly one cycle.
  - A grant therefore lasts at most HOLD_MAX cycles.
  - release_i on the expiry cycle wins: normal release, timeout stays 0.
  - Counter clears on entry to GRANT and on rst.
- Undefined: no counter logic. timeout tied to 0; the grant is held indefinitely until release_i or rst.

Decomposition:
- Package grant_dec_pkg:
  - typedef enum logic {IDLE, GRANT} gd_state_t;
  - localparam IDX_W_DEF=3;
  - localparam HOLD_MAX_DEF=15.
- Sub-module onehot_dec: purely combinational binary-to-one-hot, parameterised IDX_W, output N bits, feeding the grant register. It is reusable and the inverse of the priority encoder.
- FSM, registers and counter stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_idx=5 -> grant=0, grant_valid=0, in_ready=0 during reset. in_ready=1 the first cycle after deassert.
- Basic decode: in_idx=6, in_valid=1 in IDLE -> next cycle grant=8'b0100_0000, grant_idx=6, grant_valid=1, in_ready=0.
- Release and back-to-back: hold 3 cycles, pulse release_i, with in_idx=0 pending -> grant=0 the next cycle and in_ready=1. in_idx=0 accepted, grant=8'b0000_0001 one cycle later.
- Busy ignore: while granting idx 2, drive in_idx=7, in_valid=1 -> grant stays 8'b0000_0100 and in_ready stays 0 until release.
- Timeout (GRANT_TIMEOUT_EN, HOLD_MAX=4): grant idx 3, no release -> grant=8'b0000_1000 for exactly 4 cycles, then grant=0 with timeout=1 for 1 cycle.
- Timeout vs release tie (GRANT_TIMEOUT_EN, HOLD_MAX=4): release_i on the 4th grant cycle -> grant drops, timeout stays 0. Without the macro, the same no-release stimulus keeps the grant for 100 cycles.

Source files
------------

// File: rtl/grant_decoder3to8_pkg.sv
// -----------------------------------------------------------------------------
// grant_dec_pkg
// Shared types and defaults for the registered 3-to-8 grant decoder.
//   gd_state_t   : decoder state (IDLE waiting for an index, GRANT holding one)
//   IDX_W_DEF    : default encoded index width (8 grant lines)
//   HOLD_MAX_DEF : default forced-release limit, used only when the decoder is
//                  built with GRANT_TIMEOUT_EN defined
// -----------------------------------------------------------------------------
package grant_dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } gd_state_t;

  localparam int IDX_W_DEF    = 3;
  localparam int HOLD_MAX_DEF = 15;

endpackage : grant_dec_pkg

// File: rtl/grant_decoder3to8_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Purely combinational binary-to-one-hot decoder; the inverse of the 8-to-3
// priority encoder. Every index value maps to exactly one asserted line.
// Ports:
//   in_idx  [IDX_W-1:0]  binary index
//   onehot  [N-1:0]      one-hot decode, N = 2**IDX_W
// -----------------------------------------------------------------------------
module onehot_dec
  import grant_dec_pkg::*;
#(
  parameter  int IDX_W = IDX_W_DEF,
  localparam int N     = 2 ** IDX_W
) (
  input  logic [IDX_W-1:0] in_idx,
  output logic [N-1:0]     onehot
);

  for (genvar gi = 0; gi < N; gi++) begin : g_line
    assign onehot[gi] = (in_idx == IDX_W'(gi));
  end

endmodule : onehot_dec

// File: rtl/grant_decoder3to8.sv
// -----------------------------------------------------------------------------
// grant_decoder3to8
// Registered 3-to-8 grant decoder sitting between the priority encoder and the
// eight requesting clients. Accepts one index through a valid/ready handshake,
// drives the matching one-hot grant and holds it until the granted client
// pulses release_i (or, in the timeout build, until HOLD_MAX cycles elapse).
//
// Build option: define GRANT_TIMEOUT_EN to add the hold counter and the
// forced-release timeout. Without it, timeout is constant 0 and a grant is
// held until release_i or rst.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_idx       encoded index from the priority encoder
//   in_valid     in_idx is valid
//   in_ready     decoder can accept an index this cycle (state-only, no
//                combinational path from in_valid)
//   grant        registered one-hot grant, all-zero when idle
//   grant_valid  a grant is currently held
//   grant_idx    registered copy of the accepted index (meaningful while
//                grant_valid=1, holds last value in IDLE)
//   release_i    granted client frees the grant
//   timeout      one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module grant_decoder3to8
  import grant_dec_pkg::*;
#(
  parameter  int IDX_W    = IDX_W_DEF,
  parameter  int HOLD_MAX = HOLD_MAX_DEF,
  localparam int N        = 2 ** IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  input  logic             release_i,
  output logic             timeout
);

  // A zero hold limit would make the expiry compare meaningless.
  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("grant_decoder3to8: HOLD_MAX must be >= 1");
  end

  gd_state_t        r_state;
  logic [N-1:0]     r_grant;
  logic             r_grant_valid;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_timeout;

  logic [N-1:0]     w_onehot;
  logic             w_accept;

`ifdef GRANT_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic             w_expire;

  // Counter holds (grant cycles elapsed - 1); equal to HOLD_MAX-1 on the
  // last cycle the grant may be held.
  assign w_expire = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
`endif

  onehot_dec #(
    .IDX_W (IDX_W)
  ) u_onehot_dec (
    .in_idx (in_idx),
    .onehot (w_onehot)
  );

  // Ready depends only on state and reset, so a producer may wait for ready
  // before raising valid without creating a combinational loop.
  assign in_ready = (r_state == IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_timeout     <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      r_hold_cnt    <= '0;
`endif
    end else begin
      // timeout is a single-cycle pulse; cleared unless re-armed below
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state       <= GRANT;
            r_grant       <= w_onehot;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= in_idx;
`ifdef GRANT_TIMEOUT_EN
            r_hold_cnt    <= '0;
`endif
          end
        end
        GRANT: begin
          // release_i takes priority over expiry on the same cycle
          if (release_i) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
          end
`ifdef GRANT_TIMEOUT_EN
          else if (w_expire) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b1;
          end else begin
            r_hold_cnt    <= r_hold_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          r_state       <= IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign timeout     = r_timeout;

endmodule : grant_decoder3to8

// File: tb/tb_grant_decoder3to8.sv
// -----------------------------------------------------------------------------
// tb_grant_decoder3to8
// Scoreboard bench for grant_decoder3to8 (HOLD_MAX=4). The driver applies one
// input set per cycle, pushes the reference model's expected outputs for that
// cycle into a queue and then advances the model on the clock edge. A
// separate monitor pops one entry per falling edge and compares it against
// the DUT. The model tracks "who owns the grant and for how many cycles".
// -----------------------------------------------------------------------------
module tb_grant_decoder3to8;

  localparam int IDX_W    = 3;
  localparam int N        = 8;
  localparam int HOLD_MAX = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [IDX_W-1:0] in_idx;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             release_i;
  logic             timeout;

  grant_decoder3to8 #(
    .IDX_W    (IDX_W),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_idx      (in_idx),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .release_i   (release_i),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     grant;
    logic             gv;
    logic [IDX_W-1:0] gidx;
    logic             to;
    logic             rdy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: ownership and hold age, not states.
  bit m_known = 1'b0;
  bit m_busy  = 1'b0;
  int m_idx   = 0;
  int m_age   = 0;   // grant cycles held, counting the current one
  int m_last  = 0;
  bit m_to    = 1'b0;

  function automatic exp_t model_out(bit r);
    exp_t         e;
    logic [N-1:0] one;
    one    = 1;
    e.grant = m_busy ? (one << m_idx) : '0;
    e.gv    = m_busy;
    e.gidx  = IDX_W'(m_last);
    e.to    = m_to;
    e.rdy   = !m_busy && !r;
    return e;
  endfunction

  task automatic model_update(bit r, bit v, int i, bit rel);
    if (r) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_last  = 0;
      m_age   = 0;
      m_to    = 1'b0;
    end else if (m_known) begin
      m_to = 1'b0;
      if (!m_busy) begin
        if (v) begin
          m_busy = 1'b1;
          m_idx  = i;
          m_last = i;
          m_age  = 1;
          $display("[%0t] accept idx=%0d", $time, i);
        end
      end else if (rel) begin
        $display("[%0t] release idx=%0d after %0d cycles", $time, m_idx, m_age);
        m_busy = 1'b0;
      end else if (TO_EN && m_age == HOLD_MAX) begin
        $display("[%0t] timeout idx=%0d after %0d cycles", $time, m_idx, m_age);
        m_busy = 1'b0;
        m_to   = 1'b1;
      end else begin
        m_age = m_age + 1;
      end
    end
  endtask

  task automatic step(bit r, bit v, int i, bit rel);
    rst       = r;
    in_valid  = v;
    in_idx    = IDX_W'(i);
    release_i = rel;
    if (m_known) q.push_back(model_out(r));
    @(posedge clk);
    model_update(r, v, i, rel);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected snapshot per cycle, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant",       32'(grant),       32'(e.grant));
        chk("grant_valid", 32'(grant_valid), 32'(e.gv));
        chk("grant_idx",   32'(grant_idx),   32'(e.gidx));
        chk("timeout",     32'(timeout),     32'(e.to));
        chk("in_ready",    32'(in_ready),    32'(e.rdy));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; release_i = 1'b0;

    // reset with a pending index, then first idle cycle
    step(1, 1, 5, 0);
    step(1, 1, 5, 0);
    step(0, 0, 0, 0);

    // basic decode of index 6, then release
    step(0, 1, 6, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // hold 3 cycles, release with index 0 pending, accept back-to-back
    step(0, 1, 4, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // busy: new valid index ignored while granting index 2
    step(0, 1, 2, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 7, 0);
    step(0, 1, 7, 1);
    step(0, 0, 0, 0);

    // long hold without release (times out only in the timeout build)
    step(0, 1, 3, 0);
    for (int k = 0; k < 100; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // release on the last permitted grant cycle
    step(0, 1, 3, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // reset in the middle of a grant
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
    end
    step(0, 0, 0, 0);

    // let the monitor drain, bounded to a few cycles
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_grant_decoder3to8
